// File: rtl/tc_ps_gp_pkg.sv
// Shared encodings for the PS GP0 register-window AXI3 responders.
// Burst/response codes, FSM state codes and the AXI field widths live here.
package tc_ps_gp_pkg;

    localparam int ID_W  = 12;
    localparam int LEN_W = 4;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_CAPT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Only 2/4/8/16-beat WRAP bursts have a power-of-two wrap boundary.
    function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/tc_ps_gp_rd_addr.sv
// Next-word-address generator for an AXI3 burst walking a 2^ADDR_W-word bank.
// Pure combinational; FIXED holds, INCR wraps modulo the bank, WRAP wraps on len+1 words.
module tc_ps_gp_rd_addr
    import tc_ps_gp_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o
);

    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] incr;

    // A WRAP with an illegal length falls back to plain INCR behaviour.
    always_comb begin
        mask              = '0;
        mask[LEN_W-1:0]   = len_i;
        incr              = addr_i + ADDR_W'(1);
        next_addr_o       = incr;
        if (burst_i == BURST_FIXED) begin
            next_addr_o = addr_i;
        end else if ((burst_i == BURST_WRAP) && wrap_len_ok(len_i)) begin
            next_addr_o = (addr_i & ~mask) | (incr & mask);
        end
    end

endmodule

// File: rtl/tc_ps_gp_rd.sv
// AXI3 read responder for the PS GP0 port: one outstanding burst, one bank read per beat.
// Each beat is IDLE/RESP -> FETCH (rd_en) -> CAPT (rd_data valid) -> RESP (R beat held).
module tc_ps_gp_rd
    import tc_ps_gp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h43C0_0000,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       M_AXI_GP0_0_araddr,
    input  logic [1:0]        M_AXI_GP0_0_arburst,
    input  logic [3:0]        M_AXI_GP0_0_arcache,
    input  logic [1:0]        M_AXI_GP0_0_arlock,
    input  logic [2:0]        M_AXI_GP0_0_arprot,
    input  logic [3:0]        M_AXI_GP0_0_arqos,
    input  logic [ID_W-1:0]   M_AXI_GP0_0_arid,
    input  logic [LEN_W-1:0]  M_AXI_GP0_0_arlen,
    input  logic [2:0]        M_AXI_GP0_0_arsize,
    input  logic              M_AXI_GP0_0_arvalid,
    output logic              M_AXI_GP0_0_arready,
    output logic [31:0]       M_AXI_GP0_0_rdata,
    output logic [ID_W-1:0]   M_AXI_GP0_0_rid,
    output logic [1:0]        M_AXI_GP0_0_rresp,
    output logic              M_AXI_GP0_0_rlast,
    output logic              M_AXI_GP0_0_rvalid,
    input  logic              M_AXI_GP0_0_rready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data
);

    logic [1:0]        state_q,   state_d;
    logic [ID_W-1:0]   id_q,      id_d;
    logic [LEN_W-1:0]  len_q,     len_d;
    logic [LEN_W-1:0]  beat_q,    beat_d;
    logic [1:0]        burst_q,   burst_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              ok_q,      ok_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic              rlast_q,   rlast_d;
    logic [1:0]        rresp_q,   rresp_d;
    logic [ID_W-1:0]   rid_q,     rid_d;
    logic [31:0]       rdata_q,   rdata_d;

    logic              ar_fire;
    logic              in_range;
    logic [ADDR_W-1:0] next_addr;
    logic              unused_ok;

    assign unused_ok = ^{M_AXI_GP0_0_arcache, M_AXI_GP0_0_arlock, M_AXI_GP0_0_arprot,
                         M_AXI_GP0_0_arqos, M_AXI_GP0_0_arsize, M_AXI_GP0_0_araddr[1:0]};

    assign ar_fire  = M_AXI_GP0_0_arvalid && arready_q;
    assign in_range = (M_AXI_GP0_0_araddr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);

    tc_ps_gp_rd_addr #(
        .ADDR_W (ADDR_W)
    ) u_addr (
        .addr_i      (addr_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    // ok_q folds the range check and the reserved-burst check into one flag taken at AR time.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        beat_d    = beat_q;
        burst_d   = burst_q;
        addr_d    = addr_q;
        ok_d      = ok_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_fire) begin
                    id_d    = M_AXI_GP0_0_arid;
                    len_d   = M_AXI_GP0_0_arlen;
                    burst_d = M_AXI_GP0_0_arburst;
                    addr_d  = M_AXI_GP0_0_araddr[ADDR_W+1:2];
                    ok_d    = in_range && (M_AXI_GP0_0_arburst != BURST_RSVD);
                    beat_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                rdata_d  = ok_q ? rd_data : 32'd0;
                rresp_d  = ok_q ? RESP_OKAY : RESP_SLVERR;
                rlast_d  = (beat_q == len_q);
                rid_d    = id_q;
                rvalid_d = 1'b1;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (M_AXI_GP0_0_rready) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + LEN_W'(1);
                        addr_d  = next_addr;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // arready is registered so it first rises one edge after reset release and after the last beat.
    assign arready_d = (state_d == ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            burst_q   <= '0;
            addr_q    <= '0;
            ok_q      <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            burst_q   <= burst_d;
            addr_q    <= addr_d;
            ok_q      <= ok_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
        end
    end

    // FETCH is entered exactly once per beat, so the strobe is safe for clear-on-read bits.
    assign rd_en   = (state_q == ST_FETCH) && ok_q;
    assign rd_addr = addr_q;

    assign M_AXI_GP0_0_arready = arready_q;
    assign M_AXI_GP0_0_rvalid  = rvalid_q;
    assign M_AXI_GP0_0_rlast   = rlast_q;
    assign M_AXI_GP0_0_rresp   = rresp_q;
    assign M_AXI_GP0_0_rid     = rid_q;
    assign M_AXI_GP0_0_rdata   = rdata_q;

endmodule

// File: tb/tb_tc_ps_gp_rd.sv
// Bench for tc_ps_gp_rd: a vector table of bursts against a register-bank model,
// plus hand sequences for latency, backpressure and mid-burst reset.
module tb_tc_ps_gp_rd;
    import tc_ps_gp_pkg::*;

    localparam logic [31:0] BASE = 32'h43C0_0000;
    localparam int NV = 9;

    typedef struct {
        logic [31:0]     araddr;
        logic [1:0]      burst;
        logic [3:0]      len;
        logic [11:0]     id;
        logic [1:0]      expResp;
        logic [3:0][7:0] expAddr;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [11:0] id;
    } rBeat_t;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [1:0]  arlock;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic [11:0] arid;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [11:0] rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;

    logic [31:0] bank [256];
    vec_t        vecs [NV];
    rBeat_t      expRQ[$];
    logic [7:0]  expAddrQ[$];
    rBeat_t      monBeat;
    logic [7:0]  monAddr;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int rdEnCount = 0;
    int beatsPopped = 0;
    int arAcceptEdge = 0;
    int lastRHsEdge = 0;
    int hsEdge = 0;
    logic pendingNext = 1'b0;

    tc_ps_gp_rd #(
        .BASE_ADDR (BASE),
        .ADDR_W    (8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .M_AXI_GP0_0_araddr  (araddr),
        .M_AXI_GP0_0_arburst (arburst),
        .M_AXI_GP0_0_arcache (arcache),
        .M_AXI_GP0_0_arlock  (arlock),
        .M_AXI_GP0_0_arprot  (arprot),
        .M_AXI_GP0_0_arqos   (arqos),
        .M_AXI_GP0_0_arid    (arid),
        .M_AXI_GP0_0_arlen   (arlen),
        .M_AXI_GP0_0_arsize  (arsize),
        .M_AXI_GP0_0_arvalid (arvalid),
        .M_AXI_GP0_0_arready (arready),
        .M_AXI_GP0_0_rdata   (rdata),
        .M_AXI_GP0_0_rid     (rid),
        .M_AXI_GP0_0_rresp   (rresp),
        .M_AXI_GP0_0_rlast   (rlast),
        .M_AXI_GP0_0_rvalid  (rvalid),
        .M_AXI_GP0_0_rready  (rready),
        .rd_en               (rd_en),
        .rd_addr             (rd_addr),
        .rd_data             (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register bank model: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= bank[rd_addr];
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    endtask

    task automatic reportFail(input string name, input string what);
        checks++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    function automatic logic [63:0] allOutputs();
        return {6'd0, arready, rvalid, rlast, rresp, rid, rdata, rd_en, rd_addr};
    endfunction

    function automatic logic [3:0][7:0] addrs(input logic [7:0] a0, input logic [7:0] a1,
                                              input logic [7:0] a2, input logic [7:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mkVec(input logic [31:0] a, input logic [1:0] b, input logic [3:0] l,
                                   input logic [11:0] i, input logic [1:0] r, input logic [3:0][7:0] e);
        vec_t v;
        v.araddr = a; v.burst = b; v.len = l; v.id = i; v.expResp = r; v.expAddr = e;
        return v;
    endfunction

    // Monitor: sampled on the falling edge, so every handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (rd_en) begin
            rdEnCount++;
            if (expAddrQ.size() == 0) begin
                reportFail("rdEnUnexpected", $sformatf("strobe at address 0x%0h with none pending", rd_addr));
            end else begin
                monAddr = expAddrQ.pop_front();
                checkOutput("rdAddr", 64'(rd_addr), 64'(monAddr));
                if (pendingNext) checkOutput("fetchAfterHandshake", 64'(cyc), 64'(hsEdge));
                pendingNext = 1'b0;
            end
        end
        if (rvalid && rready) begin
            if (expRQ.size() == 0) begin
                reportFail("rBeatUnexpected", $sformatf("beat data 0x%0h with none pending", rdata));
            end else begin
                monBeat = expRQ.pop_front();
                checkOutput("rBeat", 64'({rid, rresp, rlast, rdata}),
                            64'({monBeat.id, monBeat.resp, monBeat.last, monBeat.data}));
                beatsPopped++;
                if (monBeat.last) begin
                    lastRHsEdge = cyc + 1;
                    pendingNext = 1'b0;
                end else if (monBeat.resp == RESP_OKAY) begin
                    pendingNext = 1'b1;
                    hsEdge = cyc + 1;
                end
            end
        end
        if (arvalid && arready) arAcceptEdge = cyc + 1;
    end

    // Pushes the expected strobes and beats, then drives AR until accepted; returns #1 after the accept edge.
    task automatic applyStimulus(input vec_t v);
        rBeat_t b;
        logic accepted;
        for (int k = 0; k <= int'(v.len); k++) begin
            if (v.expResp == RESP_OKAY) begin
                expAddrQ.push_back(v.expAddr[k]);
                b.data = bank[v.expAddr[k]];
            end else begin
                b.data = 32'd0;
            end
            b.resp = v.expResp;
            b.last = (k == int'(v.len));
            b.id   = v.id;
            expRQ.push_back(b);
        end
        araddr  = v.araddr;
        arburst = v.burst;
        arlen   = v.len;
        arid    = v.id;
        arcache = 4'($urandom);
        arlock  = 2'($urandom);
        arprot  = 3'($urandom);
        arqos   = 4'($urandom);
        arsize  = 3'($urandom);
        arvalid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (arready) accepted = 1'b1;
        end
        if (!accepted) reportFail("arAccept", $sformatf("id 0x%0h never accepted", v.id));
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int n = 0; n < 200 && (expRQ.size() != 0 || expAddrQ.size() != 0); n++) begin
            @(posedge clk);
            #1;
        end
        if (expRQ.size() != 0 || expAddrQ.size() != 0) begin
            reportFail(name, $sformatf("%0d beats and %0d strobes still pending", expRQ.size(), expAddrQ.size()));
            expRQ.delete();
            expAddrQ.delete();
        end
    endtask

    task automatic waitBeats(input int target);
        for (int n = 0; n < 100 && beatsPopped < target; n++) begin
            @(posedge clk);
            #1;
        end
        if (beatsPopped < target) reportFail("waitBeats", $sformatf("saw %0d beats, wanted %0d", beatsPopped, target));
    endtask

    task automatic waitRvalid();
        for (int n = 0; n < 20 && !rvalid; n++) begin
            @(posedge clk);
            #1;
        end
        if (!rvalid) reportFail("waitRvalid", "rvalid never rose");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t bp, bp2, rv, after;
        int en0, p0, expCnt;

        for (int i = 0; i < 256; i++) bank[i] = {8'hC0, 8'(i), ~8'(i), 8'(i) ^ 8'h3C};
        bank[4] = 32'hDEAD_BEEF;

        vecs[0] = mkVec(BASE + 32'h10,   BURST_INCR,  4'd0, 12'h123, RESP_OKAY,   addrs(8'h04, 8'h00, 8'h00, 8'h00));
        vecs[1] = mkVec(BASE + 32'h3F8,  BURST_INCR,  4'd3, 12'hABC, RESP_OKAY,   addrs(8'hFE, 8'hFF, 8'h00, 8'h01));
        vecs[2] = mkVec(BASE + 32'h18,   BURST_WRAP,  4'd3, 12'h001, RESP_OKAY,   addrs(8'h06, 8'h07, 8'h04, 8'h05));
        vecs[3] = mkVec(BASE + 32'h24,   BURST_FIXED, 4'd2, 12'hFFF, RESP_OKAY,   addrs(8'h09, 8'h09, 8'h09, 8'h00));
        vecs[4] = mkVec(BASE + 32'h1000, BURST_INCR,  4'd1, 12'h055, RESP_SLVERR, addrs(8'h00, 8'h00, 8'h00, 8'h00));
        vecs[5] = mkVec(BASE + 32'h40,   2'd3,        4'd1, 12'h7A0, RESP_SLVERR, addrs(8'h00, 8'h00, 8'h00, 8'h00));
        vecs[6] = mkVec(BASE + 32'h88,   BURST_WRAP,  4'd2, 12'h321, RESP_OKAY,   addrs(8'h22, 8'h23, 8'h24, 8'h00));
        vecs[7] = mkVec(BASE + 32'h2C,   BURST_WRAP,  4'd1, 12'h0C4, RESP_OKAY,   addrs(8'h0B, 8'h0A, 8'h00, 8'h00));
        vecs[8] = mkVec(32'h43BF_FFF0,   BURST_INCR,  4'd0, 12'h800, RESP_SLVERR, addrs(8'h00, 8'h00, 8'h00, 8'h00));

        rst = 1'b0;
        araddr = '0; arburst = '0; arcache = '0; arlock = '0; arprot = '0;
        arqos = '0; arid = '0; arlen = '0; arsize = '0; arvalid = 1'b0;
        rready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetState", allOutputs(), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("arreadyAfterReset", 64'(arready), 64'd1);

        for (int i = 0; i < NV; i++) begin
            en0 = rdEnCount;
            applyStimulus(vecs[i]);
            if (i == 0) begin
                checkOutput("latencyRdEn", 64'({rd_en, rd_addr}), 64'({1'b1, 8'h04}));
                @(posedge clk);
                #1;
                checkOutput("latencyNoRvalidYet", 64'(rvalid), 64'd0);
                @(posedge clk);
                #1;
                checkOutput("latencyRvalid", 64'(rvalid), 64'd1);
            end
            waitDrain($sformatf("drain[%0d]", i));
            expCnt = (vecs[i].expResp == RESP_OKAY) ? int'(vecs[i].len) + 1 : 0;
            checkOutput($sformatf("rdEnCount[%0d]", i), 64'(rdEnCount - en0), 64'(expCnt));
        end

        $display("[TB] backpressure on beat 2 with a second AR pending");
        bp  = mkVec(BASE + 32'hC0,  BURST_INCR, 4'd3, 12'h3C3, RESP_OKAY, addrs(8'h30, 8'h31, 8'h32, 8'h33));
        bp2 = mkVec(BASE + 32'h100, BURST_INCR, 4'd0, 12'h00F, RESP_OKAY, addrs(8'h40, 8'h00, 8'h00, 8'h00));
        en0 = rdEnCount;
        p0  = beatsPopped;
        applyStimulus(bp);
        fork
            applyStimulus(bp2);
            begin
                waitBeats(p0 + 1);
                rready = 1'b0;
                waitRvalid();
                for (int i = 0; i < 5; i++) begin
                    checkOutput($sformatf("stall[%0d]", i), 64'({rvalid, rid, rresp, rlast, rdata}),
                                64'({1'b1, 12'h3C3, RESP_OKAY, 1'b0, bank[8'h31]}));
                    @(posedge clk);
                    #1;
                end
                rready = 1'b1;
            end
        join
        checkOutput("arAcceptAfterLast", 64'(arAcceptEdge), 64'(lastRHsEdge + 1));
        waitDrain("drainBackpressure");
        checkOutput("rdEnCountBackpressure", 64'(rdEnCount - en0), 64'd5);

        $display("[TB] reset in the middle of beat 2");
        rv    = mkVec(BASE + 32'h140, BURST_INCR, 4'd3, 12'h5A5, RESP_OKAY, addrs(8'h50, 8'h51, 8'h52, 8'h53));
        after = mkVec(BASE + 32'h84,  BURST_INCR, 4'd0, 12'h246, RESP_OKAY, addrs(8'h21, 8'h00, 8'h00, 8'h00));
        p0 = beatsPopped;
        applyStimulus(rv);
        waitBeats(p0 + 1);
        rst = 1'b0;
        #1;
        checkOutput("resetMidBurst", allOutputs(), 64'd0);
        expRQ.delete();
        expAddrQ.delete();
        pendingNext = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetHeld", allOutputs(), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("arreadyAfterMidReset", 64'(arready), 64'd1);
        en0 = rdEnCount;
        applyStimulus(after);
        waitDrain("drainAfterReset");
        checkOutput("rdEnCountAfterReset", 64'(rdEnCount - en0), 64'd1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tc_ps_gp_rd.md
# tc_ps_gp_rd

AXI3 read-channel responder for the PS GP0 master port: the read-side counterpart of the GP0 register write path. Accepts AR requests, walks the burst through a simple synchronous register-bank read port, and returns R beats with correct ID, response and last flag. It sits between the Zynq `M_AXI_GP0_0` read channels and the PL status/readback register bank.

## Interface
- `BASE_ADDR`, 32'h43C0_0000: byte base of the register window.
- `ADDR_W`, 8: word-address width of the register bank; window size is 4·2^ADDR_W bytes.
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, asynchronous assert, active-low.
- `M_AXI_GP0_0_araddr` in 32: read byte address.
- `M_AXI_GP0_0_arburst` in 2: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
- `M_AXI_GP0_0_arcache`/`arlock`/`arprot`/`arqos` in 4/2/3/4: accepted, ignored.
- `M_AXI_GP0_0_arid` in 12: transaction ID.
- `M_AXI_GP0_0_arlen` in 4: beats minus 1.
- `M_AXI_GP0_0_arsize` in 3: ignored; every beat is a 32-bit word.
- `M_AXI_GP0_0_arvalid` in 1 / `M_AXI_GP0_0_arready` out 1: AR handshake.
- `M_AXI_GP0_0_rdata` out 32, `rid` out 12, `rresp` out 2, `rlast` out 1.
- `M_AXI_GP0_0_rvalid` out 1 / `M_AXI_GP0_0_rready` in 1: R handshake.
- `rd_en` out 1: one-cycle read strobe to the register bank. Also usable as the clear-on-read qualifier.
- `rd_addr` out ADDR_W: word address for `rd_en`.
- `rd_data` in 32: bank data, valid the cycle after `rd_en`.

## Operation
- FSM states: IDLE, FETCH, CAPT, RESP.
- **IDLE**
  - `arready`=1.
  - On `arvalid&arready`: latch id, len, burst, word address (`araddr[ADDR_W+1:2]`) and in-range flag.
  - In range means `araddr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]`.
  - Clear the beat counter; go to FETCH.
- **FETCH**
  - If in range and burst ≠ 3: assert `rd_en` with `rd_addr` = current word.
  - Otherwise no strobe.
  - Go to CAPT.
- **CAPT**
  - Register `rdata` as follows:
    - in range and burst ≠ 3: `rd_data`, `rresp`=OKAY (0);
    - otherwise: 0, `rresp`=SLVERR (2).
  - `rlast` = (beat == len); `rid` = latched id. Set `rvalid`; go to RESP.
- **RESP**
  - Hold all R outputs stable while `rready`=0.
  - On `rready`: drop `rvalid`.
    - If `rlast`: go to IDLE.
    - Else: beat+1, advance address, go to FETCH.
- **Address advance**
  - FIXED: unchanged.
  - INCR: +1 word, wrapping modulo 2^ADDR_W.
  - WRAP: mask = len (legal lengths 2/4/8/16). next = (addr & ~mask) | ((addr+1) & mask).
  - WRAP with any other len is treated as INCR.
- Range is checked once, at AR. An INCR burst crossing the window top wraps inside the bank and keeps OKAY.
- Only one outstanding transaction. `arready` stays 0 from acceptance until the cycle after the final R handshake.

## Timing
- Reset values: `arready`=0, `rvalid`=0, `rlast`=0, `rresp`=0, `rid`=0, `rdata`=0, `rd_en`=0, `rd_addr`=0, state IDLE.
- `arready` rises on the first clock edge after reset release.
- Latency: AR handshake in cycle N → `rd_en` in N+1 → `rvalid` in N+3.
- Throughput: with `rready` held high, one beat every 3 cycles.
  - `rd_en` for beat k+1 occurs the cycle after the beat k handshake.
- After the last handshake in cycle M, `arready`=1 in M+1. The next AR can be accepted in M+1.
- `rd_en` fires exactly once per beat, even under backpressure. This keeps clear-on-read bits safe.
- Reset asserted mid-burst: all outputs return to reset values immediately; the burst is abandoned and no further `rd_en` is issued.
- `arvalid` while busy: ignored. It stays pending because `arready`=0.

## Structure
- Package `tc_ps_gp_pkg`:
  - burst encodings (FIXED/INCR/WRAP);
  - response codes (OKAY=0, SLVERR=2);
  - FSM state enum;
  - AXI ID width (12) and len width (4).
- Sub-module `tc_ps_gp_rd_addr`: combinational next-word-address generator. Inputs: addr, len, burst. Output: next addr.
- Top: FSM plus R output registers.

## Test plan
- Single read, `araddr`=BASE+0x10, len 0, INCR, bank word 4 = 0xDEADBEEF:
  - `rd_addr`=4 one cycle after AR;
  - rdata 0xDEADBEEF, OKAY, `rlast`=1, `rid` echoed, `rvalid` 3 cycles after AR.
- INCR len 3 from word 0xFE, `rready` held high:
  - `rd_addr` 0xFE, 0xFF, 0x00, 0x01 at 3-cycle spacing;
  - `rlast` only on beat 4.
- WRAP len 3 from word 6: addresses 6, 7, 4, 5. FIXED len 2 at word 9: three reads of 9.
- `araddr`=BASE+0x1000 with ADDR_W=8 (out of window), len 1:
  - two beats, rdata 0, `rresp`=2;
  - no `rd_en` pulse.
- `rready` low for 5 cycles on beat 2 of a 4-beat burst:
  - R outputs stable throughout;
  - exactly 4 `rd_en` pulses in total;
  - second `arvalid` stays unaccepted until the cycle after the last beat.
- Assert `rst` in the middle of beat 2: all outputs reset immediately; after release, a new single read completes normally.
